// File: rtl/sbox_bank_arbiter_pkg.sv
// Shared definitions for the masked S-box bank arbiter: requester tags and
// the width helper for the in-flight counter.
package sbox_bank_arbiter_pkg;

    localparam logic TAG_DAT = 1'b0;
    localparam logic TAG_KEY = 1'b1;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sbox_tag_pipe.sv
// LATENCY-deep {valid, tag} shift register that tracks which requester owns
// each operand inside the free-running S-box bank.
module sbox_tag_pipe #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic v_i,
    input  logic tag_i,
    output logic v_o,
    output logic tag_o
);

    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            tag_q <= '0;
        end else begin
            v_q[0]   <= v_i;
            tag_q[0] <= tag_i;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i]   <= v_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign v_o   = v_q[LATENCY-1];
    assign tag_o = tag_q[LATENCY-1];

endmodule

// File: rtl/sbox_bank_arbiter.sv
// Round-robin arbiter sharing one pipelined masked S-box bank between the
// round datapath and the key schedule; results are routed back by tag.
module sbox_bank_arbiter
    import sbox_bank_arbiter_pkg::*;
#(
    parameter int D       = 2,
    parameter int LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dat_in_valid,
    output logic                           dat_in_ready,
    input  logic [32*D-1:0]                dat_in_sh,
    input  logic                           key_in_valid,
    output logic                           key_in_ready,
    input  logic [32*D-1:0]                key_in_sh,
    input  logic                           rnd_valid,
    output logic                           rnd_ready,
    output logic [32*D-1:0]                sbox_in,
    input  logic [32*D-1:0]                sbox_out,
    output logic                           dat_out_valid,
    output logic                           key_out_valid,
    output logic [32*D-1:0]                res_sh,
    output logic                           busy,
    output logic [cnt_width(LATENCY)-1:0]  in_flight
);

    localparam int CW = cnt_width(LATENCY);

    logic          issue;
    logic          grant_key;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic          last_v;
    logic          last_tag;

    // Held in reset so that no ready or operand leaks out while rst_n is low.
    assign issue = rst_n & rnd_valid & (dat_in_valid | key_in_valid);

    // ptr_q holds the last winner; on contention the other side wins.
    assign grant_key = key_in_valid & (~dat_in_valid | (ptr_q == TAG_DAT));

    assign dat_in_ready = issue & ~grant_key;
    assign key_in_ready = issue &  grant_key;
    assign rnd_ready    = issue;

    // AND-OR select keeps the bus at zero unless an operand is granted.
    assign sbox_in = ({(32*D){dat_in_ready}} & dat_in_sh)
                   | ({(32*D){key_in_ready}} & key_in_sh);

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = grant_key;
        end
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (issue && !last_v) begin
            in_flight_d = in_flight_q + CW'(1);
        end else if (!issue && last_v) begin
            in_flight_d = in_flight_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= TAG_KEY;
            in_flight_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            in_flight_q <= in_flight_d;
        end
    end

    sbox_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .v_i   (issue),
        .tag_i (grant_key),
        .v_o   (last_v),
        .tag_o (last_tag)
    );

    assign dat_out_valid = last_v & (last_tag == TAG_DAT);
    assign key_out_valid = last_v & (last_tag == TAG_KEY);
    assign res_sh        = {(32*D){last_v}} & sbox_out;
    assign in_flight     = in_flight_q;
    assign busy          = (in_flight_q != '0);

endmodule

// File: tb/tb_sbox_bank_arbiter.sv
// Directed bench with a result scoreboard for the S-box bank arbiter; a second
// instance covers the single-cycle, three-share configuration.
module tb_sbox_bank_arbiter;

    localparam int          D1 = 2;
    localparam int          L1 = 4;
    localparam int          D2 = 3;
    localparam int          L2 = 1;
    localparam logic [63:0] BANK_K  = 64'h5A3C_96E1_0F7B_C2D4;
    localparam logic [95:0] BANK_K3 = 96'hA1B2_C3D4_E5F6_0718_293A_4B5C;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance
    logic          dat_in_valid, key_in_valid, rnd_valid;
    logic          dat_in_ready, key_in_ready, rnd_ready;
    logic [63:0]   dat_in_sh, key_in_sh, sbox_in, sbox_out, res_sh;
    logic          dat_out_valid, key_out_valid, busy;
    logic [2:0]    in_flight;
    logic [63:0]   bank_q [L1];

    sbox_bank_arbiter #(.D(D1), .LATENCY(L1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dat_in_valid  (dat_in_valid),
        .dat_in_ready  (dat_in_ready),
        .dat_in_sh     (dat_in_sh),
        .key_in_valid  (key_in_valid),
        .key_in_ready  (key_in_ready),
        .key_in_sh     (key_in_sh),
        .rnd_valid     (rnd_valid),
        .rnd_ready     (rnd_ready),
        .sbox_in       (sbox_in),
        .sbox_out      (sbox_out),
        .dat_out_valid (dat_out_valid),
        .key_out_valid (key_out_valid),
        .res_sh        (res_sh),
        .busy          (busy),
        .in_flight     (in_flight)
    );

    // Bank model: fixed latency, transform is XOR with a constant.
    always @(posedge clk) begin
        bank_q[0] <= sbox_in;
        for (int i = 1; i < L1; i++) bank_q[i] <= bank_q[i-1];
    end
    assign sbox_out = bank_q[L1-1] ^ BANK_K;

    // LATENCY=1, D=3 instance
    logic          d3_valid, k3_valid, r3_valid;
    logic          d3_ready, k3_ready, r3_ready;
    logic [95:0]   d3_sh, k3_sh, sbox_in3, sbox_out3, res3;
    logic          d3_out, k3_out, busy3;
    logic [0:0]    in_flight3;
    logic [95:0]   bank3_q;

    sbox_bank_arbiter #(.D(D2), .LATENCY(L2)) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .dat_in_valid  (d3_valid),
        .dat_in_ready  (d3_ready),
        .dat_in_sh     (d3_sh),
        .key_in_valid  (k3_valid),
        .key_in_ready  (k3_ready),
        .key_in_sh     (k3_sh),
        .rnd_valid     (r3_valid),
        .rnd_ready     (r3_ready),
        .sbox_in       (sbox_in3),
        .sbox_out      (sbox_out3),
        .dat_out_valid (d3_out),
        .key_out_valid (k3_out),
        .res_sh        (res3),
        .busy          (busy3),
        .in_flight     (in_flight3)
    );

    always @(posedge clk) bank3_q <= sbox_in3;
    assign sbox_out3 = bank3_q ^ BANK_K3;

    typedef struct {
        logic        is_key;
        logic [63:0] res;
        int          due;
    } ent_t;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_iss    = 0;
    int   n_pulse  = 0;
    logic ptr_m    = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the main instance: check at negedge, update model, step.
    task automatic cycle();
        logic        e_issue, e_key;
        logic [63:0] e_op;
        ent_t        e;
        @(negedge clk);
        e_issue = rst_n && rnd_valid && (dat_in_valid || key_in_valid);
        e_key   = key_in_valid && (!dat_in_valid || ptr_m == 1'b0);
        e_op    = !e_issue ? 64'h0 : (e_key ? key_in_sh : dat_in_sh);
        chk("rnd_ready", rnd_ready, e_issue);
        chk("dat_in_ready", dat_in_ready, e_issue && !e_key);
        chk("key_in_ready", key_in_ready, e_issue && e_key);
        chk("sbox_in", sbox_in, e_op);
        chk("in_flight", in_flight, sb.size());
        chk("busy", busy, sb.size() != 0);
        n_pulse += int'(dat_out_valid === 1'b1) + int'(key_out_valid === 1'b1);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("dat_out_valid", dat_out_valid, !e.is_key);
            chk("key_out_valid", key_out_valid, e.is_key);
            chk("res_sh", res_sh, e.res);
        end else begin
            chk("dat_out_valid_idle", dat_out_valid, 1'b0);
            chk("key_out_valid_idle", key_out_valid, 1'b0);
            chk("res_sh_idle", res_sh, 64'h0);
        end
        if (e_issue) begin
            sb.push_back('{e_key, e_op ^ BANK_K, cyc + L1});
            ptr_m = e_key;
            n_iss++;
        end
        if (!rst_n) begin
            sb.delete();
            ptr_m = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic dv, input logic kv, input logic rv);
        dat_in_valid = dv;
        key_in_valid = kv;
        rnd_valid    = rv;
        dat_in_sh    = {$urandom, $urandom};
        key_in_sh    = {$urandom, $urandom};
    endtask

    initial begin
        logic        prev_v, prev_k, e_k;
        logic [95:0] prev_op;
        int          pulse_base, iss_base;

        rst_n = 1'b0;
        drive(0, 0, 0);
        d3_valid = 0; k3_valid = 0; r3_valid = 0; d3_sh = '0; k3_sh = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle();                       // reset state: everything zero
        rst_n = 1'b1;

        // single datapath request
        drive(1, 0, 1);
        dat_in_sh = {32'h0, 32'h0011_2233};
        cycle();
        drive(0, 0, 0);
        repeat (6) cycle();

        // both valid from reset: strict alternation D,K,D,K...
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1);
            cycle();
        end
        drive(0, 0, 0);
        repeat (5) cycle();

        // randomness stalls with key held
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, (i % 2) == 0);
            cycle();
        end
        drive(1, 1, 0);
        cycle();
        drive(1, 1, 1);
        cycle();
        drive(0, 0, 0);
        repeat (5) cycle();

        // flush three in-flight issues with a one-cycle reset
        pulse_base = n_pulse;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1);
            cycle();
        end
        drive(0, 0, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        chk("flush_no_pulses", n_pulse - pulse_base, 0);

        // back-to-back stream with random contention and stalls
        pulse_base = n_pulse;
        iss_base   = n_iss;
        for (int i = 0; i < 40; i++) begin
            if (i < 12) drive(1, 1, 1);
            else drive($urandom_range(3) != 0, $urandom_range(3) != 0,
                       (i < 24) ? 1'b1 : ($urandom_range(3) != 0));
            cycle();
        end
        drive(0, 0, 0);
        repeat (6) cycle();
        chk("stream_result_count", n_pulse - pulse_base, n_iss - iss_base);

        // LATENCY=1, D=3 instance: one-cycle results, alternating grants
        prev_v = 1'b0; prev_k = 1'b0; prev_op = '0;
        for (int i = 0; i < 5; i++) begin
            d3_valid = (i < 4);
            k3_valid = (i < 4);
            r3_valid = (i < 4);
            d3_sh    = {$urandom, $urandom, $urandom};
            k3_sh    = {$urandom, $urandom, $urandom};
            @(negedge clk);
            e_k = (i % 2) == 1;
            if (i < 4) begin
                chk("l1_key_ready", k3_ready, e_k);
                chk("l1_dat_ready", d3_ready, !e_k);
                chk("l1_sbox_in", sbox_in3, e_k ? k3_sh : d3_sh);
            end
            chk("l1_dat_out", d3_out, prev_v && !prev_k);
            chk("l1_key_out", k3_out, prev_v && prev_k);
            chk("l1_res", res3, prev_v ? (prev_op ^ BANK_K3) : 96'h0);
            prev_v  = (i < 4);
            prev_k  = e_k;
            prev_op = e_k ? k3_sh : d3_sh;
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sbox_bank_arbiter.md
Name: sbox_bank_arbiter

Overview:
- Shares one pipelined 32-bit masked S-box bank (four byte S-boxes, fixed latency, fresh randomness every cycle) between the round datapath (SubBytes, one column per issue) and the key schedule (SubWord).
- Arbitrates round-robin, gates issue on randomness availability, and tags every issue.
- Routes each result back to the requester that issued it, exactly LATENCY cycles later.
- Sits between the AES state/key controllers and the S-box bank instance.

Parameters:
- D, 2, number of masking shares; every data bus is 32*D bits, share-major.
- LATENCY, 4, S-box bank latency in cycles (>=1) from sbox_in to sbox_out.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- dat_in_valid  in  1  datapath column request
- dat_in_ready  out  1  datapath request accepted this cycle
- dat_in_sh  in  32*D  datapath column shares
- key_in_valid  in  1  key-schedule word request
- key_in_ready  out  1  key request accepted this cycle
- key_in_sh  in  32*D  key word shares
- rnd_valid  in  1  randomness for the bank is fresh this cycle
- rnd_ready  out  1  randomness consumed (equals issue)
- sbox_in  out  32*D  operand to S-box bank
- sbox_out  in  32*D  result from S-box bank
- dat_out_valid  out  1  datapath result valid (1-cycle pulse)
- key_out_valid  out  1  key result valid (1-cycle pulse)
- res_sh  out  32*D  result shares (shared by both requesters)
- busy  out  1  at least one operation in flight
- in_flight  out  clog2(LATENCY+1)  number of operations in flight

Behaviour:
- Reset (rst_n low at a clock edge): tag pipeline valids, in_flight and busy cleared; priority pointer set to "datapath first".
  - All outputs low/zero from the first edge with rst_n low.
  - In-flight results are discarded: no out_valid pulses for them after reset releases.
- Issue condition: rnd_valid and (dat_in_valid or key_in_valid). rnd_ready = issue.
- Grant:
  - Only one requester valid: that requester wins.
  - Both valid: the requester opposite the pointer wins. The pointer records the last winner and updates only on issue.
  - After reset with both valid, datapath wins.
- Ready: dat_in_ready/key_in_ready are high only for the winner in an issue cycle. Both are combinational from the valids and rnd_valid; requesters must not make valid depend on ready.
- rnd_valid low: no issue, both readies low, pointer unchanged.
- sbox_in: the winner's shares in an issue cycle; all-zero otherwise. It never carries a non-granted operand (masking hygiene: no gratuitous share transitions).
- Tag pipeline: LATENCY stages of {v, tag}. Stage 0 loads {issue, grant_is_key}; stages shift every cycle unconditionally. The bank pipeline is free-running with no stall.
- Output, driven combinationally from the last tag stage and sbox_out:
  - dat_out_valid = v & ~tag; key_out_valid = v & tag.
  - res_sh = sbox_out when v, zero otherwise.
- Results have no backpressure; requesters must accept them in the valid cycle.
- Latency: exactly LATENCY cycles from the accept edge to the out_valid cycle. Throughput is one issue per cycle.
- in_flight: +1 on issue, -1 when the last stage is valid; both in the same cycle leaves it unchanged. Range is 0..LATENCY, with no overflow by construction. busy = (in_flight != 0).
- Simultaneous issue and retire in one cycle is legal and common.

Decomposition:
- Shared package holds TAG_DAT=0, TAG_KEY=1 and the clog2 width function for in_flight.
- One natural sub-module, sbox_tag_pipe: a LATENCY-deep {v, tag} shift register with synchronous active-low clear.
- The S-box bank itself stays outside this block.

Test Plan:
- Single datapath request, dat_in_sh=32'h00112233 (share1=0, D=2), rnd_valid=1 -> dat_in_ready pulses once. dat_out_valid is high exactly 4 cycles later with res_sh=sbox_out; key_out_valid never rises.
- Both valid continuously for 8 cycles from reset, rnd_valid=1 -> grants D,K,D,K,D,K,D,K. Outputs alternate dat/key starting cycle 4; in_flight rises 1,2,3,4 and holds at 4.
- rnd_valid toggling 1,0,1,0 with key_in_valid held -> key_in_ready and rnd_ready high only when rnd_valid=1; sbox_in=0 on the other cycles; pointer unchanged on stalled cycles.
- 3 issues in flight, rst_n low for one cycle -> in_flight=0 and busy=0 after that edge; no out_valid pulses for the flushed issues in the following 4 cycles.
- Back-to-back stream with retire and issue in the same cycle -> in_flight stays constant, busy stays 1, and no result is lost or duplicated (scoreboard count matches).
- LATENCY=1, D=3 build -> result one cycle after accept; bus widths 96 bits; round-robin still alternates.
